// File: rtl/signed_divider_core_if.sv
// Request/result bundle for signed_divider_core: the master drives start/a/d,
// the slave (divider) returns the registered quotient, remainder and status.
interface signed_divider_core_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             overflow;
    logic             div_by_zero;

    // start is a request pulse, sampled only when busy is low; done is a
    // one-cycle strobe marking b/remainder/flags valid, and they hold afterwards.
    modport master (
        output start, a, d,
        input  b, remainder, busy, done, overflow, div_by_zero
    );

    modport slave (
        input  start, a, d,
        output b, remainder, busy, done, overflow, div_by_zero
    );
endinterface

// File: rtl/signed_divider_core.sv
// Multi-cycle signed divider: sign/magnitude split, restoring division MSB first,
// sign fix-up. Optional macro SIGNED_DIVISION_DIVZERO_EN enables divide-by-zero handling.
module signed_divider_core #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    signed_divider_core_if.slave  bus,
    output logic [1:0]            state_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    ONE_C = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   ONE_X = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, state_next;
    logic [WIDTH-1:0] a_lat, d_lat, quo;
    logic [WIDTH:0]   mag_a, mag_d_in, mag_d, rem_acc, shifted, diff;
    logic [WIDTH-1:0] q_neg, r_mag, r_neg;
    logic             sign_a, sign_q;
    logic [CW-1:0]    cnt;
    logic             load_en, calc_en, fix_en;
    logic             is_ovf, d_zero;
    logic             unused_bits;

    // One extra bit keeps |most-negative| exact (e.g. 1000 -> 01000).
    function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] ext;
        ext = {v[WIDTH-1], v};
        return v[WIDTH-1] ? (~ext + ONE_X) : ext;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (cnt == LAST) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state != IDLE);
        load_en   = (state == IDLE) && bus.start;
        calc_en   = (state == CALC);
        fix_en    = (state == FIX);
        state_dbg = state;
    end

    always_comb begin
        mag_a       = magnitude(bus.a);
        mag_d_in    = magnitude(bus.d);
        shifted     = {rem_acc[WIDTH-1:0], quo[WIDTH-1]};
        diff        = shifted - mag_d;
        q_neg       = ~quo + ONE_W;
        r_mag       = rem_acc[WIDTH-1:0];
        r_neg       = ~r_mag + ONE_W;
        is_ovf      = (a_lat == MOST_NEG) && (&d_lat);
        d_zero      = (d_lat == '0);
        unused_bits = rem_acc[WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_lat           <= '0;
            d_lat           <= '0;
            quo             <= '0;
            mag_d           <= '0;
            rem_acc         <= '0;
            sign_a          <= 1'b0;
            sign_q          <= 1'b0;
            cnt             <= '0;
            bus.b           <= '0;
            bus.remainder   <= '0;
            bus.done        <= 1'b0;
            bus.overflow    <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            // done trails the DONE state by one edge, giving WIDTH+2 edges of latency.
            bus.done <= (state == DONE);
            if (load_en) begin
                a_lat   <= bus.a;
                d_lat   <= bus.d;
                mag_d   <= mag_d_in;
                quo     <= mag_a[WIDTH-1:0];
                // Top dividend bit seeds the partial remainder (always 0 for magnitudes).
                rem_acc <= {{WIDTH{1'b0}}, mag_a[WIDTH]};
                sign_a  <= bus.a[WIDTH-1];
                sign_q  <= bus.a[WIDTH-1] ^ bus.d[WIDTH-1];
                cnt     <= '0;
            end
            if (calc_en) begin
                cnt <= cnt + ONE_C;
                if (shifted >= mag_d) begin
                    rem_acc <= diff;
                    quo     <= {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem_acc <= shifted;
                    quo     <= {quo[WIDTH-2:0], 1'b0};
                end
            end
            if (fix_en) begin
`ifdef SIGNED_DIVISION_DIVZERO_EN
                if (d_zero) begin
                    bus.b           <= '0;
                    bus.remainder   <= a_lat;
                    bus.overflow    <= 1'b0;
                    bus.div_by_zero <= 1'b1;
                end else begin
                    bus.b           <= sign_q ? q_neg : quo;
                    bus.remainder   <= sign_a ? r_neg : r_mag;
                    bus.overflow    <= is_ovf;
                    bus.div_by_zero <= 1'b0;
                end
`else
                // Zero divisor falls through the algorithm: all-ones magnitude quotient.
                bus.b           <= sign_q ? q_neg : quo;
                bus.remainder   <= sign_a ? r_neg : r_mag;
                bus.overflow    <= is_ovf & ~d_zero;
                bus.div_by_zero <= 1'b0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_signed_divider_core.sv
// Directed + random checks of signed_divider_core against an integer-arithmetic model.
module tb_signed_divider_core;
    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;
    int         n_checks;
    int         n_errs;

    signed_divider_core_if #(.WIDTH(4)) bus ();

    signed_divider_core #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: truncating signed division, remainder follows the dividend.
    task automatic ref_div(input logic [3:0] av, input logic [3:0] dv,
                           output logic [3:0] qb, output logic [3:0] rr,
                           output logic ov, output logic dz);
        int sa, sd;
        sa = $signed(av);
        sd = $signed(dv);
        ov = 1'b0;
        dz = 1'b0;
        if (sd == 0) begin
`ifdef SIGNED_DIVISION_DIVZERO_EN
            qb = 4'h0;
            dz = 1'b1;
`else
            qb = (sa >= 0) ? 4'hF : 4'h1;
`endif
            rr = av;
        end else if (sa == -8 && sd == -1) begin
            qb = 4'h8;
            rr = 4'h0;
            ov = 1'b1;
        end else begin
            qb = 4'(sa / sd);
            rr = 4'(sa % sd);
        end
    endtask

    task automatic run_div(input logic [3:0] av, input logic [3:0] dv);
        logic [3:0] qb, rr;
        logic       ov, dz;
        int         n_edges;
        logic       got;
        ref_div(av, dv, qb, rr, ov, dz);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.d     = dv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 4'($urandom);
        bus.d     = 4'($urandom);
        n_edges   = 0;
        got       = 1'b0;
        while (!got && n_edges < 20) begin
            @(posedge clk);
            #1;
            n_edges++;
            if (n_edges == 1) chk("busy_mid", 32'(bus.busy), 32'd1);
            if (n_edges == 2) begin
                bus.start = 1'b1;
                bus.a     = 4'($urandom);
                bus.d     = 4'($urandom);
            end
            if (n_edges == 3) bus.start = 1'b0;
            if (bus.done) got = 1'b1;
        end
        chk($sformatf("latency a=%h d=%h", av, dv), 32'(n_edges), 32'd6);
        chk($sformatf("b a=%h d=%h", av, dv), 32'(bus.b), 32'(qb));
        chk($sformatf("rem a=%h d=%h", av, dv), 32'(bus.remainder), 32'(rr));
        chk($sformatf("ovf a=%h d=%h", av, dv), 32'(bus.overflow), 32'(ov));
        chk($sformatf("dz a=%h d=%h", av, dv), 32'(bus.div_by_zero), 32'(dz));
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        chk("b_hold", 32'(bus.b), 32'(qb));
    endtask

    initial begin
        logic saw_done;
        n_checks  = 0;
        n_errs    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 4'h0;
        bus.d     = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_b", 32'(bus.b), 32'd0);
        chk("rst_rem", 32'(bus.remainder), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_flags", 32'({bus.overflow, bus.div_by_zero}), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div(4'hA, 4'h2);
        run_div(4'h6, 4'h2);
        run_div(4'hB, 4'h2);
        run_div(4'hF, 4'h2);
        run_div(4'h7, 4'hD);
        run_div(4'h5, 4'h0);
        run_div(4'h8, 4'h0);
        run_div(4'h8, 4'h1);
        run_div(4'h8, 4'hF);

        // Abort mid-calculation: outputs clear at once and no done follows.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'h7;
        bus.d     = 4'h2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_b", 32'(bus.b), 32'd0);
        chk("abort_rem", 32'(bus.remainder), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_flags", 32'({bus.done, bus.overflow, bus.div_by_zero}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_div(4'h7, 4'h2);

        for (int i = 0; i < 40; i++) begin
            run_div(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end
endmodule

// File: doc/signed_divider_core.md
SIGNED_DIVIDER_CORE -- requirements
Module: signed_division

Interface
REQ-001 Parameter: WIDTH, 4, operand/result width in bits (two's complement); all values below assume WIDTH=4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 a  input  WIDTH  signed dividend.
REQ-006 d  input  WIDTH  signed divisor.
REQ-007 b  output  WIDTH  signed quotient, registered.
REQ-008 remainder  output  WIDTH  signed remainder, registered.
REQ-009 busy  output  1  high while a division is in progress.
REQ-010 done  output  1  one-cycle pulse when b/remainder become valid.
REQ-011 overflow  output  1  registered; high when the true quotient is not representable.
REQ-012 div_by_zero  output  1  registered divide-by-zero flag (see Configuration).

Function
REQ-013 States SHALL be IDLE, CALC, FIX, DONE.
REQ-014 In IDLE with start=1 at a rising edge, the block SHALL latch a and d, store |a| and |d|, capture sign bits, and enter CALC.
REQ-015 CALC SHALL perform unsigned restoring division on the magnitudes, one quotient bit per cycle, MSB first, for exactly WIDTH cycles, then enter FIX.
REQ-016 FIX SHALL negate the quotient when sign(a) XOR sign(d) is 1, negate the remainder when sign(a) is 1, load b/remainder/overflow/div_by_zero, then enter DONE.
REQ-017 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-018 Latency: done SHALL be high in the cycle following the (WIDTH+2)th rising edge after the start-sampling edge (6 edges for WIDTH=4).
REQ-019 busy SHALL be 1 in CALC, FIX and DONE, and 0 in IDLE.
REQ-020 Quotient SHALL truncate toward zero; the remainder SHALL carry the dividend's sign, with a = b*d + remainder.
REQ-021 start while busy=1 SHALL be ignored; a and d changes after latching SHALL not affect the result.
REQ-022 b, remainder and flags SHALL hold their values from DONE until the next FIX.
REQ-023 Most-negative / -1 (1000 / 1111): b=1000, remainder=0000, overflow=1; overflow SHALL be 0 for all other nonzero divisors.
REQ-024 Magnitude of the most-negative value SHALL be computed in WIDTH+1 bits internally, so 1000 is handled without loss.

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE and b, remainder, busy, done, overflow and div_by_zero to 0, including mid-operation; the aborted division produces no done.
REQ-026 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-027 Macro SIGNED_DIVISION_DIVZERO_EN: when defined, d=0 SHALL give div_by_zero=1, b=0000, remainder=a, overflow=0, with unchanged latency.
REQ-028 Without SIGNED_DIVISION_DIVZERO_EN: div_by_zero SHALL be tied to 0, and d=0 SHALL yield the raw algorithm result: b=1111 if a>=0, b=0001 if a<0, remainder=a.

Verification
REQ-029 a=1010 (-6), d=0010, start -> after 6 edges done=1, b=1101 (-3), remainder=0000.
REQ-030 a=0110, d=0010 -> b=0011, remainder=0000; a=1011 (-5), d=0010 -> b=1110 (-2), remainder=1111 (-1).
REQ-031 a=1111 (-1), d=0010 -> b=0000, remainder=1111; a=0111, d=1101 (-3) -> b=1110, remainder=0001.
REQ-032 a=1000, d=1111 -> b=1000, remainder=0000, overflow=1.
REQ-033 a=0101, d=0000 -> with macro: div_by_zero=1, b=0000, remainder=0101; without macro: b=1111, remainder=0101, div_by_zero=0.
REQ-034 rst pulsed during CALC -> all outputs 0 at once and no done pulse; second start while busy is ignored; a new start after rst completes normally.
